// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned DLY_W = 2;

  localparam logic [1:0] TUSE_NONE = 2'd3;
  localparam logic [1:0] TNEW_PC8  = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  localparam int unsigned CNT_W_DEF       = 4;

  typedef struct packed {
    logic [REG_W-1:0] ad;
    logic             we;
    logic [DLY_W-1:0] delay;
  } stage_t;

  // Remaining latency counts down one per stage and sticks at zero.
  function automatic logic [DLY_W-1:0] sat_dec(input logic [DLY_W-1:0] x);
    return (x == '0) ? '0 : x - DLY_W'(1);
  endfunction

  // A source stalls when an E or M producer of it is not ready by its use time.
  function automatic logic src_hazard(input logic [REG_W-1:0] src,
                                      input logic [DLY_W-1:0] tuse,
                                      input stage_t e, input stage_t m);
    return (tuse != TUSE_NONE) && (src != '0) &&
           ((e.we && (e.ad == src) && (e.delay > tuse)) ||
            (m.we && (m.ad == src) && (m.delay > tuse)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-stage request and scoreboard/stall response bundle of the hazard controller.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic [REG_W-1:0] D_rs;
  logic [REG_W-1:0] D_rt;
  logic [DLY_W-1:0] D_tuse_rs;
  logic [DLY_W-1:0] D_tuse_rt;
  logic [REG_W-1:0] D_wad;
  logic             D_we;
  logic [DLY_W-1:0] D_tnew;
  logic             D_md_start;
  logic             D_md_div;
  logic             D_md_use;

  logic             stall;
  logic [REG_W-1:0] E_Ad2;
  logic [REG_W-1:0] M_Ad2;
  logic [REG_W-1:0] W_Ad2;
  logic             E_we;
  logic             M_we;
  logic             W_we;
  logic [DLY_W-1:0] E_delay;
  logic [DLY_W-1:0] M_delay;
  logic             md_busy;

  modport master (
    output D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_wad, D_we, D_tnew,
           D_md_start, D_md_div, D_md_use,
    input  stall, E_Ad2, M_Ad2, W_Ad2, E_we, M_we, W_we, E_delay, M_delay, md_busy
  );

  modport slave (
    input  D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_wad, D_we, D_tnew,
           D_md_start, D_md_div, D_md_use,
    output stall, E_Ad2, M_Ad2, W_Ad2, E_we, M_we, W_we, E_delay, M_delay, md_busy
  );

endinterface

// File: rtl/hazard_ctrl_md_busy_cnt.sv
// HI/LO unit occupancy: loads the op latency when a mult/div sits in E, then counts down.
module md_busy_cnt
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic div,
  output logic busy_c
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // The issuing cycle itself already counts as busy.
  assign busy_c = start | (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller: E/M/W destination scoreboard, source hazard check, HI/LO busy tracking.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input logic         clk,
  input logic         rst_n,
  hazard_ctrl_if.slave hz
);

  stage_t           e_q;
  stage_t           m_q;
  logic [REG_W-1:0] w_ad_q;
  logic             w_we_q;
  logic             e_md_q;
  logic             e_div_q;

  logic             md_busy_c;
  logic             h_rs_c;
  logic             h_rt_c;
  logic             h_md_c;
  logic             stall_c;

  always_comb begin
    h_rs_c  = src_hazard(hz.D_rs, hz.D_tuse_rs, e_q, m_q);
    h_rt_c  = src_hazard(hz.D_rt, hz.D_tuse_rt, e_q, m_q);
    h_md_c  = (hz.D_md_use | hz.D_md_start) & md_busy_c;
    stall_c = h_rs_c | h_rt_c | h_md_c;
  end

  // Stalled cycles push a bubble into E; M and W always advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q     <= '0;
      m_q     <= '0;
      w_ad_q  <= '0;
      w_we_q  <= 1'b0;
      e_md_q  <= 1'b0;
      e_div_q <= 1'b0;
    end else begin
      if (stall_c) begin
        e_q     <= '0;
        e_md_q  <= 1'b0;
        e_div_q <= 1'b0;
      end else begin
        e_q     <= '{ad: hz.D_wad, we: hz.D_we && (hz.D_wad != '0), delay: hz.D_tnew};
        e_md_q  <= hz.D_md_start;
        e_div_q <= hz.D_md_start & hz.D_md_div;
      end
      m_q    <= '{ad: e_q.ad, we: e_q.we, delay: sat_dec(e_q.delay)};
      w_ad_q <= m_q.ad;
      w_we_q <= m_q.we;
    end
  end

  md_busy_cnt #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (e_md_q),
    .div    (e_div_q),
    .busy_c (md_busy_c)
  );

  assign hz.stall   = stall_c;
  assign hz.E_Ad2   = e_q.ad;
  assign hz.E_we    = e_q.we;
  assign hz.E_delay = e_q.delay;
  assign hz.M_Ad2   = m_q.ad;
  assign hz.M_we    = m_q.we;
  assign hz.M_delay = m_q.delay;
  assign hz.W_Ad2   = w_ad_q;
  assign hz.W_we    = w_we_q;
  assign hz.md_busy = md_busy_c;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios plus random instruction streams vs a cycle-history model.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int MULT_C = 5;
  localparam int DIV_C  = 10;
  localparam int HIST_N = 4096;

  typedef struct {
    logic [4:0] rs;  logic [1:0] tur;
    logic [4:0] rt;  logic [1:0] tut;
    logic [4:0] wad; logic we; logic [1:0] tnew;
    logic ms; logic md; logic mu;
  } din_t;

  typedef struct { logic [4:0] ad; logic we; int tnew; } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if bus ();

  hazard_ctrl #(.MULT_CYCLES(MULT_C), .DIV_CYCLES(DIV_C), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (bus)
  );

  int   vectors = 0;
  int   errors  = 0;
  ent_t hist [HIST_N];  // what occupies E in each cycle
  int   cyc;
  int   md_free;        // first cycle in which the HI/LO unit is idle again
  bit   exp_stall;
  logic obs_stall, obs_busy;
  logic [4:0] obs_m_ad;
  logic [1:0] obs_m_dly;
  ent_t EMPTY = '{5'd0, 1'b0, 0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic din_t mk(logic [4:0] rs, logic [1:0] tur, logic [4:0] rt, logic [1:0] tut,
                              logic [4:0] wad, logic we, logic [1:0] tnew,
                              logic ms, logic md, logic mu);
    din_t d;
    d = '{rs, tur, rt, tut, wad, we, tnew, ms, md, mu};
    return d;
  endfunction

  function automatic din_t nop();
    return mk(0, TUSE_NONE, 0, TUSE_NONE, 0, 0, TNEW_PC8, 0, 0, 0);
  endfunction

  task automatic apply(input din_t d);
    bus.D_rs = d.rs;   bus.D_tuse_rs = d.tur;
    bus.D_rt = d.rt;   bus.D_tuse_rt = d.tut;
    bus.D_wad = d.wad; bus.D_we = d.we; bus.D_tnew = d.tnew;
    bus.D_md_start = d.ms; bus.D_md_div = d.md; bus.D_md_use = d.mu;
  endtask

  // A reader is blocked if a producer in E (age 0) or M (age 1) still needs more than tuse cycles.
  function automatic bit src_haz(logic [4:0] s, logic [1:0] tuse);
    if (tuse == TUSE_NONE || s == 5'd0) return 1'b0;
    for (int k = 0; k < 2; k++) begin
      int rem = hist[cyc-k].tnew - k;
      if (rem < 0) rem = 0;
      if (hist[cyc-k].we && hist[cyc-k].ad == s && rem > int'(tuse)) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic step(input din_t d);
    bit   es, busy;
    ent_t e0, e1, e2;
    int   m_dly;
    apply(d);
    @(negedge clk);
    e0 = hist[cyc]; e1 = hist[cyc-1]; e2 = hist[cyc-2];
    busy  = (cyc < md_free);
    es    = src_haz(d.rs, d.tur) || src_haz(d.rt, d.tut) || ((d.mu || d.ms) && busy);
    m_dly = (e1.tnew > 0) ? e1.tnew - 1 : 0;
    check("stall",   32'(bus.stall),   32'(es));
    check("md_busy", 32'(bus.md_busy), 32'(busy));
    check("E_Ad2",   32'(bus.E_Ad2),   32'(e0.ad));
    check("E_we",    32'(bus.E_we),    32'(e0.we));
    check("E_delay", 32'(bus.E_delay), 32'(e0.tnew));
    check("M_Ad2",   32'(bus.M_Ad2),   32'(e1.ad));
    check("M_we",    32'(bus.M_we),    32'(e1.we));
    check("M_delay", 32'(bus.M_delay), 32'(m_dly));
    check("W_Ad2",   32'(bus.W_Ad2),   32'(e2.ad));
    check("W_we",    32'(bus.W_we),    32'(e2.we));
    obs_stall = bus.stall; obs_busy = bus.md_busy;
    obs_m_ad  = bus.M_Ad2; obs_m_dly = bus.M_delay;
    exp_stall = es;
    @(posedge clk);
    if (!es) begin
      hist[cyc+1] = '{d.wad, d.we && (d.wad != 5'd0), int'(d.tnew)};
      if (d.ms) md_free = cyc + 1 + (d.md ? DIV_C : MULT_C) + 1;
    end else begin
      hist[cyc+1] = EMPTY;
    end
    cyc++;
    if (cyc >= HIST_N - 2) begin
      $display("FAIL history_overflow: cycle %0d exceeds bench capacity", cyc);
      $fatal(1);
    end
    #1;
  endtask

  // Hold one instruction in D until it is accepted; ns = stalled cycles seen on the DUT.
  task automatic issue(input din_t d, output int ns);
    ns = 0;
    forever begin
      step(d);
      if (!obs_stall) break;
      ns++;
      if (ns >= 64) begin
        check("stall_timeout", 32'(ns), 32'(0));
        break;
      end
    end
  endtask

  task automatic drain();
    repeat (3) step(nop());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    apply(nop());
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall",   32'(bus.stall),   32'(0));
    check("rst_md_busy", 32'(bus.md_busy), 32'(0));
    check("rst_E_we",    32'(bus.E_we),    32'(0));
    check("rst_M_delay", 32'(bus.M_delay), 32'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc = 2;
    for (int i = 0; i <= 2; i++) hist[i] = EMPTY;
    md_free   = 0;
    exp_stall = 1'b0;
  endtask

  function automatic din_t rand_din();
    din_t d;
    d.rs   = 5'($urandom_range(0, 3));
    d.rt   = 5'($urandom_range(0, 3));
    d.tur  = 2'($urandom_range(0, 3));
    d.tut  = 2'($urandom_range(0, 3));
    d.wad  = 5'($urandom_range(0, 3));
    d.we   = 1'($urandom_range(0, 1));
    d.tnew = 2'($urandom_range(0, 2));
    d.ms   = ($urandom_range(0, 15) == 0);
    d.md   = 1'($urandom_range(0, 1));
    d.mu   = ($urandom_range(0, 7) == 0);
    return d;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   ns;
    din_t d;
    do_reset();

    // load-use: one bubble, then the load sits in M with one cycle left
    issue(mk(0, TUSE_NONE, 0, TUSE_NONE, 8, 1, TNEW_LOAD, 0, 0, 0), ns);
    issue(mk(8, 2'd1, 0, TUSE_NONE, 10, 1, TNEW_ALU, 0, 0, 0), ns);
    check("loaduse_stalls", 32'(ns), 32'(1));
    check("loaduse_M_Ad2", 32'(obs_m_ad), 32'(8));
    check("loaduse_M_delay", 32'(obs_m_dly), 32'(1));
    drain();

    // branch reading an ALU result, then a load result
    issue(mk(0, TUSE_NONE, 0, TUSE_NONE, 9, 1, TNEW_ALU, 0, 0, 0), ns);
    issue(mk(9, 2'd0, 0, TUSE_NONE, 0, 0, TNEW_PC8, 0, 0, 0), ns);
    check("br_alu_stalls", 32'(ns), 32'(1));
    drain();
    issue(mk(0, TUSE_NONE, 0, TUSE_NONE, 9, 1, TNEW_LOAD, 0, 0, 0), ns);
    issue(mk(9, 2'd0, 0, TUSE_NONE, 0, 0, TNEW_PC8, 0, 0, 0), ns);
    check("br_load_stalls", 32'(ns), 32'(2));
    drain();

    // $0 writes are dropped; unused sources never stall
    issue(mk(0, TUSE_NONE, 0, TUSE_NONE, 0, 1, TNEW_LOAD, 0, 0, 0), ns);
    issue(mk(0, 2'd0, 0, 2'd0, 0, 0, TNEW_PC8, 0, 0, 0), ns);
    check("zero_reg_stalls", 32'(ns), 32'(0));
    issue(mk(0, TUSE_NONE, 0, TUSE_NONE, 5, 1, TNEW_LOAD, 0, 0, 0), ns);
    issue(mk(0, TUSE_NONE, 5, TUSE_NONE, 0, 0, TNEW_PC8, 0, 0, 0), ns);
    check("unused_rt_stalls", 32'(ns), 32'(0));
    drain();

    // mult/div followed by mflo
    issue(mk(0, TUSE_NONE, 0, TUSE_NONE, 0, 0, TNEW_PC8, 1, 0, 0), ns);
    issue(mk(0, TUSE_NONE, 0, TUSE_NONE, 2, 1, TNEW_ALU, 0, 0, 1), ns);
    check("mult_mflo_stalls", 32'(ns), 32'(1 + MULT_C));
    check("mult_busy_after", 32'(obs_busy), 32'(0));
    drain();
    issue(mk(0, TUSE_NONE, 0, TUSE_NONE, 0, 0, TNEW_PC8, 1, 1, 0), ns);
    issue(mk(0, TUSE_NONE, 0, TUSE_NONE, 2, 1, TNEW_ALU, 0, 0, 1), ns);
    check("div_mflo_stalls", 32'(ns), 32'(1 + DIV_C));
    check("div_busy_after", 32'(obs_busy), 32'(0));
    drain();

    // back-to-back div: the second waits for the first, then reloads the full latency
    issue(mk(0, TUSE_NONE, 0, TUSE_NONE, 0, 0, TNEW_PC8, 1, 1, 0), ns);
    issue(mk(0, TUSE_NONE, 0, TUSE_NONE, 0, 0, TNEW_PC8, 1, 1, 0), ns);
    check("div_div_stalls", 32'(ns), 32'(1 + DIV_C));
    step(nop());
    issue(mk(0, TUSE_NONE, 0, TUSE_NONE, 2, 1, TNEW_ALU, 0, 0, 1), ns);
    check("div_reload_stalls", 32'(ns), 32'(DIV_C));
    drain();

    // asynchronous reset in the middle of a div stall
    step(mk(0, TUSE_NONE, 0, TUSE_NONE, 0, 0, TNEW_PC8, 1, 1, 0));
    step(nop());
    step(mk(0, TUSE_NONE, 0, TUSE_NONE, 7, 1, TNEW_LOAD, 0, 0, 0));
    repeat (2) step(mk(0, TUSE_NONE, 0, TUSE_NONE, 2, 1, TNEW_ALU, 0, 0, 1));
    apply(mk(0, TUSE_NONE, 0, TUSE_NONE, 2, 1, TNEW_ALU, 0, 0, 1));
    #1;
    check("pre_rst_stall", 32'(bus.stall), 32'(1));
    check("pre_rst_W_Ad2", 32'(bus.W_Ad2), 32'(7));
    check("pre_rst_W_we",  32'(bus.W_we),  32'(1));
    rst_n = 1'b0;
    #1;
    check("async_rst_stall",   32'(bus.stall),   32'(0));
    check("async_rst_md_busy", 32'(bus.md_busy), 32'(0));
    check("async_rst_W_Ad2",   32'(bus.W_Ad2),   32'(0));
    check("async_rst_W_we",    32'(bus.W_we),    32'(0));
    check("async_rst_M_Ad2",   32'(bus.M_Ad2),   32'(0));
    check("async_rst_E_delay", 32'(bus.E_delay), 32'(0));
    do_reset();

    // random instruction stream; a stalled instruction stays in D
    d = nop();
    for (int i = 0; i < 1500; i++) begin
      if (!exp_stall) d = rand_din();
      step(d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and stall controller for the 5-stage MIPS pipeline.
- Owns the E/M/W destination scoreboard (write address, write-enable, remaining-latency "delay") that feeds the forwarding mux block.
- Compares D-stage source registers and their use-times against that scoreboard, and tracks the multiply/divide unit's busy window.
- Emits a single stall that freezes PC/F/D and injects a bubble into E.

Parameters:
- MULT_CYCLES, 5, cycles the HI/LO unit is busy after a mult/multu enters E.
- DIV_CYCLES, 10, cycles the HI/LO unit is busy after a div/divu enters E.
- CNT_W, 4, busy-counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- D_rs  in  5  D-stage rs address.
- D_rt  in  5  D-stage rt address.
- D_tuse_rs  in  2  cycles until rs is consumed (0=D, 1=E, 2=M); 3=not used.
- D_tuse_rt  in  2  same encoding, for rt.
- D_wad  in  5  D-stage destination register.
- D_we  in  1  D-stage instruction writes GPR.
- D_tnew  in  2  cycles after E-entry until the result is forwardable (0 jal/lui, 1 ALU, 2 load).
- D_md_start  in  1  D instruction is mult/multu/div/divu.
- D_md_div  in  1  qualifies D_md_start: 1=div, 0=mult.
- D_md_use  in  1  D instruction is mfhi/mflo/mthi/mtlo.
- stall  out  1  freeze PC/F/D; bubble into E.
- E_Ad2, M_Ad2, W_Ad2  out  5 each  destination per stage.
- E_we, M_we, W_we  out  1 each  write-enable per stage.
- E_delay, M_delay  out  2 each  remaining cycles before the stage's value is valid.
- md_busy  out  1  HI/LO unit occupied.

Behaviour:
- Reset is asynchronous and active-low; clock is single (clk, rst_n). While rst_n=0, all of the following are 0: Ad2, we, delay, E_md (internal) and the busy counter. stall is then 0 by construction.
- Scoreboard update, on every rising clk edge:
  - stall=0: E <= {D_wad, D_we & (D_wad!=0), D_tnew}; E_md <= D_md_start.
  - stall=1: E <= bubble {0,0,0}; E_md <= 0.
  - Always: M <= {E_Ad2, E_we, sat_dec(E_delay)}, and W <= {M_Ad2, M_we}.
  - sat_dec(x) = (x==0) ? 0 : x-1. Delay never wraps.
- Register hazard, combinational, evaluated for each source s in {rs, rt}:
  - h_s = (tuse_s != 3) && (s != 0) && ((E_we && E_Ad2==s && E_delay > tuse_s) || (M_we && M_Ad2==s && M_delay > tuse_s)).
  - W is always forwardable and never stalls.
- MD busy counter:
  - When E_md=1 at a clock edge, the counter loads DIV_CYCLES if the latched div flag is set, else MULT_CYCLES.
  - Otherwise it decrements while nonzero and saturates at 0.
  - md_busy = E_md | (cnt != 0).
- MD hazard: h_md = (D_md_use | D_md_start) & md_busy.
- stall = h_rs | h_rt | h_md, combinational from D inputs and registered state. No registered latency. stall stays high until the hazard clears; there is no timeout.
- Simultaneous events:
  - A bubble inserted while a load sits in E still advances the load to M, with delay reduced by 1.
  - Multiple hazards collapse into one stall.
  - rst_n asserted mid-stall clears all state immediately, so stall drops asynchronously.
- Write address 0 is never recorded as a write (we forced 0), so $0 never causes a stall.

Decomposition:
- Shared package holds:
  - TUSE_NONE=2'd3.
  - TNEW_* encodings (PC8=0, ALU=1, LOAD=2).
  - MULT_CYCLES/DIV_CYCLES defaults.
  - A stage-tuple typedef {ad[4:0], we, delay[1:0]}.
- One sub-module, md_busy_cnt: load/decrement counter taking start, div and returning busy. Everything else stays in hazard_ctrl.

Test Plan:
- Load-use: lw $8 (tnew 2) then addu using $8 with tuse_rs=1 → stall=1 for exactly 1 cycle; next cycle M_Ad2=8, M_delay=1, stall=0.
- Branch after ALU op: addu $9 (tnew 1) then beq $9 (tuse 0) → stall for 1 cycle; after lw $9 (tnew 2) → stall for 2 cycles.
- $0 and unused sources: D_wad=0/D_we=1 then reader of $0 → E_we=0, no stall; tuse_rt=3 with rt matching E_Ad2 → no stall.
- Mult then mflo: mult issued, mflo follows → stall=1 for 1+MULT_CYCLES=6 cycles. With div instead → 11 cycles. After the stall ends, md_busy=0.
- Back-to-back div: second div stalls until md_busy=0, then the counter reloads to 10.
- Reset mid-operation: assert rst_n=0 while stalling on div (cnt=7) → stall, md_busy and all Ad2/we/delay go to 0 immediately, without waiting for clk.
